// File: rtl/mar_pkg.sv
// Shared types and defaults for the burst-capable memory address register.
package mar_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_STRIDE    = 4;
  localparam int unsigned DEF_BURST_MAX = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ
  } mar_state_e;

  // Beat-count width: wide enough to hold BURST_MAX and one value above it.
  function automatic int unsigned bl_w(input int unsigned burst_max);
    return $clog2(burst_max) + 1;
  endfunction

endpackage

// File: rtl/mar_burst_unit_if.sv
// Control/memory-side signal bundle for mar_burst_unit.
interface mar_burst_unit_if
  import mar_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BURST_MAX = DEF_BURST_MAX
);
  localparam int unsigned BL_W = bl_w(BURST_MAX);

  logic              load;
  logic [ADDR_W-1:0] address_input;
  logic              start;
  logic [BL_W-1:0]   burst_len;
  logic              mem_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mar_output;
  logic              busy;
  logic              done;
  logic              align_err;

  modport master (
    output load, address_input, start, burst_len, mem_ready,
    input  mem_valid, mar_output, busy, done, align_err
  );

  modport slave (
    input  load, address_input, start, burst_len, mem_ready,
    output mem_valid, mar_output, busy, done, align_err
  );
endinterface

// File: rtl/mar_beat_counter.sv
// Remaining-beat counter: loaded with the burst length, decremented per accept.
module mar_beat_counter #(
  parameter int unsigned BL_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [BL_W-1:0] len_i,
  input  logic            dec_i,
  output logic            last_beat_o
);
  logic [BL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = len_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - BL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_beat_o = (cnt_q == BL_W'(1));
endmodule

// File: rtl/mar_burst_unit.sv
// Memory address register with valid/ready request handshake and strided bursts.
module mar_burst_unit
  import mar_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned STRIDE      = DEF_STRIDE,
  parameter int unsigned BURST_MAX   = DEF_BURST_MAX,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst,
  mar_burst_unit_if.slave  bus
);
  localparam int unsigned BL_W = bl_w(BURST_MAX);

  mar_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aerr_q, aerr_d;
  logic              cnt_load, accept, last_beat, len_ok, misaligned;

  assign accept     = valid_q && bus.mem_ready;
  assign len_ok     = (bus.burst_len != '0) && (bus.burst_len <= BL_W'(BURST_MAX));
  assign misaligned = (ALIGN_CHECK != 0) &&
                      ((bus.address_input & ADDR_W'(STRIDE - 1)) != '0);

  mar_beat_counter #(.BL_W(BL_W)) u_beats (
    .clk         (clk),
    .rst         (rst),
    .load_i      (cnt_load),
    .len_i       (bus.burst_len),
    .dec_i       (accept),
    .last_beat_o (last_beat)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    aerr_d   = aerr_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          addr_d = bus.address_input;
          aerr_d = misaligned;
        end else if (bus.start && len_ok && !aerr_q) begin
          state_d  = REQ;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      REQ: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(STRIDE);
          if (last_beat) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      aerr_q  <= aerr_d;
    end
  end

  assign bus.mem_valid  = valid_q;
  assign bus.mar_output = addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.align_err  = aerr_q;
endmodule

// File: doc/mar_burst_unit.md
Name: mar_burst_unit

Overview:
- Parametrised successor to the memory address register: holds the current memory address.
- Drives a valid/ready address handshake toward memory.
- Auto-increments the address by a fixed stride for single or burst transfers.
- Sits between control unit (load/start) and memory interface; flags misaligned addresses.

Parameters:
ADDR_W, 32, address width in bits
STRIDE, 4, byte increment per accepted beat (power of two, >=1)
BURST_MAX, 8, maximum beats per transfer (>=1)
ALIGN_CHECK, 1, 1 = flag addresses not aligned to STRIDE; 0 = never flag

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
load  in  1  capture address_input into address register
address_input  in  ADDR_W  new address
start  in  1  begin transfer of burst_len beats from current address
burst_len  in  BL_W = $clog2(BURST_MAX)+1  requested beat count
mem_ready  in  1  memory accepts current address
mem_valid  out  1  address on mar_output is a valid request
mar_output  out  ADDR_W  current address
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after final beat accepted
align_err  out  1  loaded address misaligned

Behaviour:
- All outputs registered. Reset (rst=1 at a rising edge): mar_output=0, mem_valid=0, busy=0, done=0, align_err=0, beat counter=0, state IDLE. rst overrides all other inputs, including mid-burst (mem_valid drops after that edge; no done pulse).
- States: IDLE, REQ.
- IDLE, load=1:
  - mar_output <= address_input on the edge.
  - align_err <= ALIGN_CHECK && (address_input mod STRIDE != 0).
- IDLE, start=1, load=0:
  - Accepted only if 1 <= burst_len <= BURST_MAX and align_err=0.
  - If accepted: state <= REQ, mem_valid <= 1, busy <= 1, beats_left <= burst_len.
  - If not accepted: start is ignored, with no state change and no done pulse.
- load and start in the same cycle: load wins; start is dropped.
- REQ:
  - mem_valid=1. mar_output stays stable while mem_valid && !mem_ready.
  - load and start are ignored.
- Beat accepted (mem_valid && mem_ready at an edge):
  - mar_output <= mar_output + STRIDE, modulo 2^ADDR_W. Wrap is silent (0xFFFFFFFC+4 -> 0x00000000) and does not set align_err.
  - beats_left decrements.
- Last beat accepted (beats_left==1):
  - state <= IDLE; mem_valid <= 0, busy <= 0; done <= 1 for exactly one cycle.
  - mar_output then points one stride past the last address.
- Latency:
  - start sampled at edge N -> mem_valid=1 after edge N.
  - With mem_ready held high, a burst of L beats sees its last accept at edge N+L, and done is high for the cycle after edge N+L.
- New start is legal in the cycle done is high (state is IDLE).
- align_err is sticky until the next load in IDLE or rst.
- mem_ready is ignored when mem_valid=0.

Decomposition:
- Package mar_pkg:
  - state enum (IDLE, REQ).
  - default ADDR_W/STRIDE/BURST_MAX constants.
  - BL_W localparam function.
- One natural sub-module: mar_beat_counter. It loads burst_len, decrements on accept, and outputs last_beat.
- The remaining FSM and address datapath stay in mar_burst_unit.

Test Plan:
- Reset and load: rst 2 cycles, then load 0x0000000F with ALIGN_CHECK=1 -> mar_output=0x0000000F, align_err=1. A following start with burst_len=1 -> ignored: mem_valid stays 0, no done.
- Single beat: load 0x00000100, start burst_len=1, mem_ready=1 -> mem_valid high one cycle at 0x100. Then mar_output=0x104, done pulses once, busy=0.
- Burst with backpressure: load 0x00001000, start burst_len=4, mem_ready pattern 1,0,0,1,1,1 -> addresses accepted 0x1000, 0x1004, 0x1008, 0x100C. mar_output holds 0x1004 during the stall cycles; final mar_output=0x1010; one done pulse.
- Wrap: load 0xFFFFFFF8, burst_len=3, ready=1 -> accepts 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. End mar_output=0x00000004, align_err=0.
- Illegal/simultaneous cases:
  - burst_len=0 or 9 with BURST_MAX=8 -> ignored.
  - load 0x200 + start in the same cycle -> mar_output=0x200, mem_valid=0.
  - load during REQ -> ignored.
- Reset mid-burst: burst_len=8, assert rst after 3 accepts -> next cycle all outputs 0, no done. A subsequent load/start operates normally.
